// File: rtl/calc_pkg.sv
// Shared definitions for the calc engine slice: FSM state encoding,
// operation codes, flag bit positions and a small decode helper.
package calc_pkg;

  // State encoding kept as fixed constants so existing waveform/debug
  // tooling that decodes the raw 2-bit state still works.
  typedef logic [1:0] state_t;
  localparam state_t IDLE = 2'd0;
  localparam state_t DIV  = 2'd1;
  localparam state_t DONE = 2'd2;

  typedef logic [2:0] fun_t;
  localparam fun_t FUN_ADD = 3'b000;
  localparam fun_t FUN_SUB = 3'b001;
  localparam fun_t FUN_MUL = 3'b010;
  localparam fun_t FUN_DIV = 3'b011;
  localparam fun_t FUN_MOD = 3'b100;

  // flags = {err, dbz, cb}
  localparam int unsigned FLAG_CB  = 0;
  localparam int unsigned FLAG_DBZ = 1;
  localparam int unsigned FLAG_ERR = 2;

  function automatic logic is_divide(input fun_t f);
    return (f == FUN_DIV) || (f == FUN_MOD);
  endfunction

endpackage

// File: rtl/calc_if.sv
// Request/response bundle between a requester (master) and the engine (slave).
//   in_valid/in_ready : request handshake carrying a, b, fun
//   out_valid/out_ready : response handshake carrying out, flags {err,dbz,cb}
interface calc_if
  import calc_pkg::*;
#(
  parameter int unsigned WIDTH = 8
);
  logic                 in_valid;
  logic                 in_ready;
  logic [WIDTH-1:0]     a;
  logic [WIDTH-1:0]     b;
  fun_t                 fun;
  logic                 out_valid;
  logic                 out_ready;
  logic [2*WIDTH-1:0]   out;
  logic [2:0]           flags;

  modport master (
    output in_valid, a, b, fun, out_ready,
    input  in_ready, out_valid, out, flags
  );

  modport slave (
    input  in_valid, a, b, fun, out_ready,
    output in_ready, out_valid, out, flags
  );
endinterface

// File: rtl/calc_divider.sv
// Restoring unsigned divider, one quotient bit per clock.
//   clk, rst_n : clock, synchronous active-low reset
//   start      : load a/b and perform the first step in the same cycle
//   a, b       : dividend, divisor (b must be non-zero)
//   busy       : remaining steps in progress
//   done       : one-cycle pulse, quotient/remainder valid
//   quotient, remainder : result registers
module calc_divider
#(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder
);

  logic [WIDTH-1:0] q_q, r_q, d_q;
  logic [5:0]       cnt_q;

  logic [WIDTH-1:0] src_q, src_r, src_d;
  logic [WIDTH:0]   shifted, trial;
  logic [WIDTH-1:0] next_q, next_r;

  // The first step is taken on the start edge from the raw operands, so the
  // full division spends WIDTH edges in total and done lands in time for the
  // caller to register the result on the following edge.
  always_comb begin
    src_q   = start ? a  : q_q;
    src_r   = start ? '0 : r_q;
    src_d   = start ? b  : d_q;
    shifted = {src_r, src_q[WIDTH-1]};
    trial   = shifted - {1'b0, src_d};
    if (!trial[WIDTH]) begin
      next_r = trial[WIDTH-1:0];
      next_q = {src_q[WIDTH-2:0], 1'b1};
    end else begin
      next_r = shifted[WIDTH-1:0];
      next_q = {src_q[WIDTH-2:0], 1'b0};
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      q_q   <= '0;
      r_q   <= '0;
      d_q   <= '0;
      cnt_q <= '0;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      done <= 1'b0;
      if (start) begin
        q_q   <= next_q;
        r_q   <= next_r;
        d_q   <= b;
        cnt_q <= 6'(WIDTH - 1);
        busy  <= 1'b1;
      end else if (busy) begin
        q_q   <= next_q;
        r_q   <= next_r;
        cnt_q <= cnt_q - 6'd1;
        if (cnt_q == 6'd1) begin
          busy <= 1'b0;
          done <= 1'b1;
        end
      end
    end
  end

  assign quotient  = q_q;
  assign remainder = r_q;

endmodule

// File: rtl/calc_engine.sv
// Handshaked arithmetic engine: add/sub/mul in one cycle, div/mod via the
// iterative divider (WIDTH+1 cycle latency), divide-by-zero and illegal
// opcodes reported through flags.
//   clk, rst_n : clock, synchronous active-low reset
//   bus        : calc_if slave (in_valid/in_ready/a/b/fun, out_valid/out_ready/out/flags)
module calc_engine
  import calc_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input  logic   clk,
  input  logic   rst_n,
  calc_if.slave  bus
);

  state_t             state_q;
  fun_t               fun_q;
  logic [2*WIDTH-1:0] out_q;
  logic [2:0]         flags_q;

  logic [2*WIDTH-1:0] ext_a, ext_b;
  logic [WIDTH:0]     sum;
  logic [2*WIDTH-1:0] alu_out;
  logic [2:0]         alu_flags;

  logic               accept, div_start;
  logic               div_busy, div_done;
  logic [WIDTH-1:0]   div_quo, div_rem;

  assign accept    = (state_q == IDLE) && bus.in_valid;
  assign div_start = accept && is_divide(bus.fun) && (bus.b != '0);

  assign ext_a = {{WIDTH{1'b0}}, bus.a};
  assign ext_b = {{WIDTH{1'b0}}, bus.b};
  assign sum   = {1'b0, bus.a} + {1'b0, bus.b};

  // Single-cycle results; the div/mod arm is only used when b == 0.
  always_comb begin
    alu_out   = '0;
    alu_flags = '0;
    case (bus.fun)
      FUN_ADD: begin
        alu_out            = {{(WIDTH-1){1'b0}}, sum};
        alu_flags[FLAG_CB] = sum[WIDTH];
      end
      FUN_SUB: begin
        alu_out            = ext_a - ext_b;
        alu_flags[FLAG_CB] = (bus.a < bus.b);
      end
      FUN_MUL: begin
        alu_out            = ext_a * ext_b;
        alu_flags[FLAG_CB] = |alu_out[2*WIDTH-1:WIDTH];
      end
      FUN_DIV, FUN_MOD: begin
        alu_out             = '1;
        alu_flags[FLAG_DBZ] = 1'b1;
      end
      default: begin
        alu_out             = '0;
        alu_flags[FLAG_ERR] = 1'b1;
      end
    endcase
  end

  calc_divider #(.WIDTH(WIDTH)) u_div (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (div_start),
    .a         (bus.a),
    .b         (bus.b),
    .busy      (div_busy),
    .done      (div_done),
    .quotient  (div_quo),
    .remainder (div_rem)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      fun_q   <= FUN_ADD;
      out_q   <= '0;
      flags_q <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (accept) begin
            fun_q <= bus.fun;
            if (div_start) begin
              state_q <= DIV;
            end else begin
              out_q   <= alu_out;
              flags_q <= alu_flags;
              state_q <= DONE;
            end
          end
        end
        DIV: begin
          if (div_done) begin
            out_q   <= (fun_q == FUN_DIV) ? {div_rem, div_quo}
                                          : {{WIDTH{1'b0}}, div_rem};
            flags_q <= '0;
            state_q <= DONE;
          end else if (!div_busy) begin
            // Divider idle without a completion: nothing to wait for.
            state_q <= IDLE;
          end
        end
        DONE: begin
          if (bus.out_ready) state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.in_ready  = (state_q == IDLE);
  assign bus.out_valid = (state_q == DONE);
  assign bus.out       = out_q;
  assign bus.flags     = flags_q;

endmodule

// File: tb/tb_calc_engine.sv
// Directed bench for calc_engine at WIDTH=8.
module tb_calc_engine;
  import calc_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   errors = 0;
  int   lat;

  calc_if #(.WIDTH(8)) bus ();

  calc_engine #(.WIDTH(8)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Present one request, then count edges until out_valid (bounded).
  task automatic run_op(input logic [7:0] ta, input logic [7:0] tb_v, input logic [2:0] tf,
                        output int l);
    bus.a = ta; bus.b = tb_v; bus.fun = tf; bus.in_valid = 1'b1;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    l = 1;
    while (!bus.out_valid && l < 40) begin
      @(posedge clk); #1;
      l++;
    end
  endtask

  task automatic pop(input string tag);
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
    check({tag, "_in_ready_after"}, bus.in_ready, 1'b1);
    check({tag, "_out_valid_after"}, bus.out_valid, 1'b0);
  endtask

  task automatic result(input string tag, input int exp_lat, input logic [15:0] exp_out,
                        input logic [2:0] exp_flags);
    check({tag, "_lat"},   lat, exp_lat);
    check({tag, "_out"},   bus.out, exp_out);
    check({tag, "_flags"}, bus.flags, exp_flags);
    check({tag, "_in_ready"}, bus.in_ready, 1'b0);
    pop(tag);
  endtask

  initial begin
    bus.in_valid = 1'b0; bus.out_ready = 1'b0;
    bus.a = '0; bus.b = '0; bus.fun = FUN_ADD;

    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    check("rst_out_valid", bus.out_valid, 1'b0);
    check("rst_in_ready",  bus.in_ready, 1'b1);
    check("rst_out",       bus.out, 16'h0000);
    check("rst_flags",     bus.flags, 3'b000);

    run_op(8'd200, 8'd100, FUN_ADD, lat);
    result("add_200_100", 1, 16'd300, 3'b001);
    check("idle_hold_out",   bus.out, 16'd300);
    check("idle_hold_flags", bus.flags, 3'b001);

    run_op(8'd1, 8'd2, FUN_ADD, lat);
    result("add_1_2", 1, 16'd3, 3'b000);
    run_op(8'd255, 8'd255, FUN_ADD, lat);
    result("add_255_255", 1, 16'd510, 3'b001);

    run_op(8'd3, 8'd5, FUN_SUB, lat);
    result("sub_3_5", 1, 16'hFFFE, 3'b001);
    run_op(8'd5, 8'd3, FUN_SUB, lat);
    result("sub_5_3", 1, 16'h0002, 3'b000);

    // mul with 5 cycles of backpressure and junk requests on the input side
    run_op(8'd255, 8'd255, FUN_MUL, lat);
    check("mul_ff_lat", lat, 1);
    bus.a = 8'd1; bus.b = 8'd1; bus.fun = FUN_ADD; bus.in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      check("bp_out",       bus.out, 16'hFE01);
      check("bp_flags",     bus.flags, 3'b001);
      check("bp_in_ready",  bus.in_ready, 1'b0);
      check("bp_out_valid", bus.out_valid, 1'b1);
      @(posedge clk); #1;
    end
    bus.in_valid = 1'b0;
    check("bp_out_final", bus.out, 16'hFE01);
    pop("bp");

    run_op(8'd16, 8'd15, FUN_MUL, lat);
    result("mul_16_15", 1, 16'h00F0, 3'b000);

    run_op(8'd100, 8'd7, FUN_DIV, lat);
    result("div_100_7", 9, 16'h020E, 3'b000);
    run_op(8'd100, 8'd7, FUN_MOD, lat);
    result("mod_100_7", 9, 16'h0002, 3'b000);
    run_op(8'd255, 8'd1, FUN_DIV, lat);
    result("div_255_1", 9, 16'h00FF, 3'b000);
    run_op(8'd3, 8'd200, FUN_DIV, lat);
    result("div_3_200", 9, 16'h0300, 3'b000);

    run_op(8'd9, 8'd0, FUN_DIV, lat);
    result("div_by_zero", 1, 16'hFFFF, 3'b010);
    run_op(8'd5, 8'd0, FUN_MOD, lat);
    result("mod_by_zero", 1, 16'hFFFF, 3'b010);
    run_op(8'd9, 8'd3, 3'b111, lat);
    result("illegal_111", 1, 16'h0000, 3'b100);
    run_op(8'd9, 8'd3, 3'b101, lat);
    result("illegal_101", 1, 16'h0000, 3'b100);

    // reset asserted in the 4th DIV cycle aborts the divide
    bus.a = 8'd100; bus.b = 8'd7; bus.fun = FUN_DIV; bus.in_valid = 1'b1;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    repeat (3) begin
      @(posedge clk); #1;
    end
    check("abort_in_div_in_ready", bus.in_ready, 1'b0);
    check("abort_in_div_out_valid", bus.out_valid, 1'b0);
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    check("abort_in_ready", bus.in_ready, 1'b1);
    check("abort_out",      bus.out, 16'h0000);
    check("abort_flags",    bus.flags, 3'b000);
    for (int i = 0; i < 12; i++) begin
      check("abort_no_out_valid", bus.out_valid, 1'b0);
      @(posedge clk); #1;
    end

    run_op(8'd200, 8'd13, FUN_DIV, lat);
    result("div_after_abort", 9, 16'h050F, 3'b000);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
